strobe_mon: RTL and testbench
=============================

# strobe_mon

Clock-enable strobe monitor: the receiving end of the divider's `clk_en` strobe. It measures the number of `clk_in` cycles between consecutive strobe pulses and checks each period against the expected divide ratio. It declares lock after a run of correct periods and flags period errors and missing strobes. It sits beside every divider instance in the DSM DAC datapath, so that a stalled or mis-set sample-rate enable is caught in hardware and by the bench.

## Interface
Parameters:
- `DIV`, default 4: expected strobe period in `clk_in` cycles; must be ≥ 1.
- `LOCK_CNT`, default 4: number of consecutive correct periods required to declare lock; must be ≥ 1.
- `CNT_W`, default 16: width of the period counter; must satisfy `2**CNT_W > 2*DIV`.

Ports:
- `clk_in`, input, 1 bit: the single clock. All logic is on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `clk_en`, input, 1 bit: the strobe under test, synchronous to `clk_in`. Each high cycle counts as one strobe.
- `err_clr`, input, 1 bit: synchronous clear for the sticky `err` flag.
- `period`, output, `CNT_W` bits: the last measured strobe period.
- `period_vld`, output, 1 bit: one-cycle pulse indicating that `period` has just been updated.
- `locked`, output, 1 bit: high while the strobe period has been stable at `DIV`.
- `timeout`, output, 1 bit: one-cycle pulse when no strobe arrives within `2*DIV` cycles.
- `err`, output, 1 bit: sticky flag set on a period mismatch or timeout while locked.

## Operation
- The block uses an internal cycle counter `cnt` (`CNT_W` bits) and a good-period counter `good` (sized to hold `LOCK_CNT`).
- The state machine has three states: SEARCH, ACQUIRE and LOCKED.
- SEARCH:
  - `cnt` and `good` are held at 0.
  - On a strobe: `cnt` is set to 1 and the state moves to ACQUIRE. No `period_vld` is produced for this first strobe.
- ACQUIRE and LOCKED, on a cycle with no strobe:
  - `cnt` increments by 1.
  - If `cnt == 2*DIV` on that cycle: pulse `timeout`, set `good` to 0, and move to SEARCH.
  - If the timeout happens while LOCKED, also set `err` and drop `locked`.
- ACQUIRE and LOCKED, on a strobe:
  - Load `period` with `cnt`, pulse `period_vld`, and set `cnt` to 1.
  - If `cnt == DIV`, the period is good: increment `good`, saturating at `LOCK_CNT`.
    - In ACQUIRE, when `good` reaches `LOCK_CNT`, move to LOCKED.
  - If `cnt != DIV`, the period is bad: set `good` to 0.
    - In LOCKED, a bad period also sets `err` and returns the state to ACQUIRE.
- Period definition: a strobe at cycle t followed by the next strobe at cycle t+N measures `period == N`. If `clk_en` is held high continuously, the measured period is 1.
- `locked` is 1 exactly when the state is LOCKED.
- `err` is cleared by `err_clr`. If `err_clr` and an `err` set condition occur in the same cycle, the set wins.
- With `DIV == 1`, a continuously high strobe is correct and locks after `LOCK_CNT` periods.

## Timing
- All outputs are registered.
- Reset values: `period = 0`, `period_vld = 0`, `locked = 0`, `timeout = 0`, `err = 0`, state SEARCH, `cnt = 0`, `good = 0`.
- Asserting `rst` at any point, including mid-lock, forces these values immediately.
- After deassertion, the first strobe only starts a measurement; the first `period_vld` comes with the second strobe.
- Latencies, all measured from the edge that samples the triggering event:
  - `period_vld` and `period`: valid in the cycle after the sampled strobe.
  - `locked` rise: cycle after the strobe that completes the `LOCK_CNT`-th good period.
  - `locked` fall and `err` rise: cycle after the bad strobe or the timeout cycle.
- `timeout` is asserted in the cycle after the cycle in which `cnt == 2*DIV` is sampled with `clk_en` low.
- A strobe arriving on the cycle where `cnt == 2*DIV` is a measurement with `period = 2*DIV`, which is bad; no timeout is generated.
- `cnt` never exceeds `2*DIV`, so no wrap-around occurs under legal parameters.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately; drive strobes every 4 cycles → the first `period_vld` appears one cycle after the 2nd strobe, with `period = 4`.
- **Lock:** `DIV=4`, `LOCK_CNT=4`, strobes every 4 cycles → `period_vld` pulses carry 4; `locked` rises one cycle after the 5th strobe and stays high; `err = 0`.
- **Glitch while locked:** after lock, one strobe arrives 3 cycles after the previous one → `period = 3`, `locked` falls and `err` rises the next cycle; 4 further good periods relock; `err` remains 1.
- **Stall:** after lock, stop strobes → `timeout` pulses once, 8 cycles after the last strobe plus 1 cycle of latency; `locked` falls; state returns to SEARCH; no further `period_vld` until strobes resume and two more arrive.
- **Error clear:** pulse `err_clr` with no event → `err` goes to 0; pulse `err_clr` in the same cycle as a bad strobe while locked → `err` stays 1.
- **Reset mid-lock and edge cases:** assert `rst` while locked → `locked` = 0 immediately. `DIV=1` with `clk_en` held high → `locked` after `LOCK_CNT` periods. `DIV=4` with `clk_en` held high → `period = 1` repeatedly and never locks.

Source files
------------

// File: rtl/strobe_mon_if.sv
// rtl/strobe_mon_if.sv - strobe and status bundle between a strobe source/observer and strobe_mon
//
// Signals:
//   clk_en     strobe under test, one strobe per high cycle
//   err_clr    synchronous clear of the sticky error flag
//   period     last measured strobe period, in clk_in cycles
//   period_vld one-cycle pulse when period has just been updated
//   locked     high while the strobe period is stable at the expected ratio
//   timeout    one-cycle pulse when the strobe has gone missing
//   err        sticky period/timeout error flag
// Modports: master drives the strobe and clear, slave is the monitor.
interface strobe_mon_if #(
    parameter int CNT_W = 16
);
    logic             clk_en;
    logic             err_clr;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             timeout;
    logic             err;

    modport master (
        output clk_en, err_clr,
        input  period, period_vld, locked, timeout, err
    );

    modport slave (
        input  clk_en, err_clr,
        output period, period_vld, locked, timeout, err
    );
endinterface

// File: rtl/strobe_mon.sv
// rtl/strobe_mon.sv - clock-enable strobe period monitor with lock, timeout and sticky error
//
// Measures the clk_in cycles between consecutive clk_en strobes, compares
// each period with DIV, declares lock after LOCK_CNT consecutive good
// periods and flags bad periods or missing strobes.
//
// Ports:
//   clk_in  single rising-edge clock
//   rst     asynchronous active-high reset
//   bus     strobe_mon_if slave modport (clk_en, err_clr in;
//           period, period_vld, locked, timeout, err out, all registered)
module strobe_mon #(
    parameter int DIV      = 4,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic         clk_in,
    input  logic         rst,
    strobe_mon_if.slave  bus
);
    localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  DIV_C     = CNT_W'(DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(2 * DIV);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [GOOD_W-1:0]  good_q;
    logic [CNT_W-1:0]   period_q;
    logic               period_vld_q;
    logic               locked_q;
    logic               timeout_q;
    logic               err_q;

    // Good-period count after accepting one more good period (saturating).
    logic [GOOD_W-1:0]  good_d;
    assign good_d = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            cnt_q        <= '0;
            good_q       <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            period_vld_q <= 1'b0;
            timeout_q    <= 1'b0;
            // Clear first so that any set below in the same cycle wins.
            if (bus.err_clr) begin
                err_q <= 1'b0;
            end

            case (state_q)
                SEARCH: begin
                    cnt_q  <= '0;
                    good_q <= '0;
                    // First strobe only opens a measurement window.
                    if (bus.clk_en) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= ACQUIRE;
                    end
                end

                ACQUIRE, LOCKED: begin
                    if (!bus.clk_en) begin
                        if (cnt_q == CNT_MAX) begin
                            timeout_q <= 1'b1;
                            good_q    <= '0;
                            cnt_q     <= '0;
                            state_q   <= SEARCH;
                            locked_q  <= 1'b0;
                            if (state_q == LOCKED) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        period_q     <= cnt_q;
                        period_vld_q <= 1'b1;
                        // The strobe cycle itself is cycle 1 of the next period.
                        cnt_q        <= CNT_W'(1);
                        if (cnt_q == DIV_C) begin
                            good_q <= good_d;
                            if (state_q == ACQUIRE && good_d == GOOD_MAX) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            good_q <= '0;
                            if (state_q == LOCKED) begin
                                err_q    <= 1'b1;
                                state_q  <= ACQUIRE;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q  <= SEARCH;
                    cnt_q    <= '0;
                    good_q   <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;
    assign bus.locked     = locked_q;
    assign bus.timeout    = timeout_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_strobe_mon.sv
// tb/tb_strobe_mon.sv - directed self-checking bench for strobe_mon
module tb_strobe_mon;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    strobe_mon_if #(.CNT_W(16)) ifa ();
    strobe_mon_if #(.CNT_W(16)) ifb ();

    strobe_mon #(.DIV(4), .LOCK_CNT(4), .CNT_W(16)) dut_a (
        .clk_in (clk),
        .rst    (rst),
        .bus    (ifa)
    );

    strobe_mon #(.DIV(1), .LOCK_CNT(4), .CNT_W(16)) dut_b (
        .clk_in (clk),
        .rst    (rst),
        .bus    (ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle on DUT A; outputs sampled 1 time unit after the edge.
    task automatic step(input logic en, input logic clr);
        ifa.clk_en  = en;
        ifa.err_clr = clr;
        @(posedge clk);
        #1;
        ifa.clk_en  = 1'b0;
        ifa.err_clr = 1'b0;
    endtask

    // n-1 quiet cycles then a strobe; err_clr pulsed on cycle clr_at (1..n, 0 = none).
    task automatic gap(input int n, input logic exp_vld, input int exp_per,
                       input int clr_at, input logic exp_lock, input logic exp_err);
        for (int i = 1; i <= n; i++) begin
            step(i == n, i == clr_at);
            chk("gap_timeout", int'(ifa.timeout), 0);
            if (i < n) begin
                chk("gap_vld_quiet", int'(ifa.period_vld), 0);
            end else begin
                chk("gap_vld", int'(ifa.period_vld), int'(exp_vld));
                if (exp_vld) chk("gap_period", int'(ifa.period), exp_per);
                chk("gap_locked", int'(ifa.locked), int'(exp_lock));
                chk("gap_err", int'(ifa.err), int'(exp_err));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"},  int'(ifa.period), 0);
        chk({tag, "_vld"},     int'(ifa.period_vld), 0);
        chk({tag, "_locked"},  int'(ifa.locked), 0);
        chk({tag, "_timeout"}, int'(ifa.timeout), 0);
        chk({tag, "_err"},     int'(ifa.err), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        ifa.clk_en  = 1'b0;
        ifa.err_clr = 1'b0;
        ifb.clk_en  = 1'b0;
        ifb.err_clr = 1'b0;
        #1;
        chk_all_zero("rst_init");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("rst_rel");

        // First strobe only starts a measurement, then lock after 4 good periods.
        step(1'b1, 1'b0);
        chk("first_vld", int'(ifa.period_vld), 0);
        for (int k = 1; k <= 4; k++) gap(4, 1'b1, 4, 0, k == 4, 1'b0);

        // Glitch while locked: period 3, lock lost, err set; relock keeps err.
        gap(3, 1'b1, 3, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) gap(4, 1'b1, 4, 0, k == 4, 1'b1);

        // Clear with no event, then a clear colliding with a bad strobe.
        gap(4, 1'b1, 4, 1, 1'b1, 1'b0);
        gap(5, 1'b1, 5, 5, 1'b0, 1'b1);

        // Relock and clear err on the way for the stall test.
        for (int k = 1; k <= 4; k++) gap(4, 1'b1, 4, (k == 4) ? 1 : 0, k == 4, k != 4);

        // Stall: timeout on the 8th quiet edge, exactly once.
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b0);
            chk("stall_timeout", int'(ifa.timeout), int'(i == 8));
            chk("stall_vld", int'(ifa.period_vld), 0);
            if (i >= 8) begin
                chk("stall_locked", int'(ifa.locked), 0);
                chk("stall_err", int'(ifa.err), 1);
            end
        end
        step(1'b1, 1'b0);
        chk("resume_first_vld", int'(ifa.period_vld), 0);
        gap(4, 1'b1, 4, 0, 1'b0, 1'b1);

        // Strobe exactly at cnt == 2*DIV: a bad period of 8, no timeout.
        gap(8, 1'b1, 8, 0, 1'b0, 1'b1);

        // Strobe held high with DIV=4: period 1 every cycle, never locks.
        for (int k = 0; k < 6; k++) gap(1, 1'b1, 1, 0, 1'b0, 1'b1);

        // Relock, then asynchronous reset in the middle of a cycle.
        for (int k = 1; k <= 4; k++) gap(4, 1'b1, 4, 0, k == 4, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0);
        chk("post_rst_first_vld", int'(ifa.period_vld), 0);
        gap(4, 1'b1, 4, 0, 1'b0, 1'b0);

        // DIV=1 instance with strobe held high: locks after 4 periods.
        ifb.clk_en = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            chk("div1_locked", int'(ifb.locked), int'(e >= 5));
            chk("div1_vld", int'(ifb.period_vld), int'(e >= 2));
            if (e >= 2) chk("div1_period", int'(ifb.period), 1);
            chk("div1_err", int'(ifb.err), 0);
        end
        ifb.clk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
